// File: rtl/fib_controller.sv
// Fibonacci sequencer driving a small external register file: entries 0/1 hold
// F(j)/F(j+1), entry 2 receives the sum, and two moves shift the window up.
module fib_controller #(
  parameter int REGF_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            n_terms,
  output logic [4:0]            RS,
  output logic [4:0]            RT,
  input  logic [15:0]           out1,
  input  logic [15:0]           out2,
  output logic [1:0]            RD,
  output logic [REGF_WIDTH-1:0] Data_in,
  output logic                  enW,
  output logic                  busy,
  output logic                  done,
  output logic [REGF_WIDTH-1:0] result,
  output logic                  overflow,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT0 = 3'd1,
    INIT1 = 3'd2,
    ADD   = 3'd3,
    MOV0  = 3'd4,
    MOV1  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [REGF_WIDTH-1:0] result_q, result_d;
  logic                  ovf_q, ovf_d;

  logic [1:0]            rs_sel, rt_sel;
  logic [REGF_WIDTH:0]   sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    rs_sel   = 2'd0;
    rt_sel   = 2'd0;
    RD       = 2'd0;
    Data_in  = '0;
    enW      = 1'b0;
    done     = 1'b0;
    // Extra top bit captures the carry used for the sticky overflow flag.
    sum      = {1'b0, out1[REGF_WIDTH-1:0]} + {1'b0, out2[REGF_WIDTH-1:0]};

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d      = n_terms;
          result_d = '0;
          ovf_d    = 1'b0;
          state_d  = INIT0;
        end
      end
      INIT0: begin
        RD      = 2'd0;
        Data_in = '0;
        enW     = 1'b1;
        state_d = INIT1;
      end
      INIT1: begin
        RD      = 2'd1;
        Data_in = REGF_WIDTH'(1);
        enW     = 1'b1;
        cnt_d   = (n_q == 8'd0) ? 8'd0 : n_q - 8'd1;
        if (cnt_d != 8'd0) begin
          state_d = ADD;
        end else begin
          result_d = (n_q == 8'd0) ? '0 : REGF_WIDTH'(1);
          state_d  = DONE;
        end
      end
      ADD: begin
        rs_sel  = 2'd0;
        rt_sel  = 2'd1;
        RD      = 2'd2;
        Data_in = sum[REGF_WIDTH-1:0];
        enW     = 1'b1;
        if (sum[REGF_WIDTH]) ovf_d = 1'b1;
        state_d = MOV0;
      end
      MOV0: begin
        rs_sel  = 2'd1;
        RD      = 2'd0;
        Data_in = out1[REGF_WIDTH-1:0];
        enW     = 1'b1;
        state_d = MOV1;
      end
      MOV1: begin
        rs_sel  = 2'd2;
        RD      = 2'd1;
        Data_in = out1[REGF_WIDTH-1:0];
        enW     = 1'b1;
        cnt_d   = cnt_q - 8'd1;
        if (cnt_d != 8'd0) begin
          state_d = ADD;
        end else begin
          result_d = out1[REGF_WIDTH-1:0];
          state_d  = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign RS        = {3'b000, rs_sel};
  assign RT        = {3'b000, rt_sel};
  assign busy      = (state_q == INIT0) || (state_q == INIT1) || (state_q == ADD) ||
                     (state_q == MOV0)  || (state_q == MOV1);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fib_controller.sv
// Directed bench for fib_controller with a behavioural 4-entry register file
// and a bus monitor that checks every write against a reference sum.
module tb_fib_controller;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   n_terms;
  logic [4:0]   RS, RT;
  logic [15:0]  out1, out2;
  logic [1:0]   RD;
  logic [W-1:0] Data_in;
  logic         enW, busy, done, overflow;
  logic [W-1:0] result;
  logic [2:0]   dbg_state;

  logic [W-1:0] regs [4];
  int tests = 0;
  int fails = 0;
  int add_cnt = 0;

  fib_controller #(.REGF_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .n_terms(n_terms),
    .RS(RS), .RT(RT), .out1(out1), .out2(out2), .RD(RD),
    .Data_in(Data_in), .enW(enW), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else if (enW) begin
      regs[RD] <= Data_in;
    end
  end
  assign out1 = {8'h00, regs[RS[1:0]]};
  assign out2 = {8'h00, regs[RT[1:0]]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] fib_mod(input int n);
    logic [W-1:0] a, b, t;
    a = '0;
    b = W'(1);
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      check("no_write_in_reset", {31'd0, enW}, 32'd0);
    end else begin
      check("rs_hi_zero", {29'd0, RS[4:2]}, 32'd0);
      check("rt_hi_zero", {29'd0, RT[4:2]}, 32'd0);
      if (enW) check("no_write_entry3", {31'd0, RD == 2'd3}, 32'd0);
      if (enW && RD == 2'd2) begin
        add_cnt++;
        check("add_rt", {27'd0, RT}, 32'd1);
        check("add_data", {24'd0, Data_in}, {24'd0, W'(regs[0] + regs[1])});
      end else begin
        check("rt_idle_zero", {27'd0, RT}, 32'd0);
      end
    end
  end

  task automatic wait_done(input string tag, output int lat);
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) check({tag, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run(input int n, input logic [W-1:0] exp_res, input logic exp_ovf,
                     input string tag);
    int lat, adds0, nn;
    nn = (n == 0) ? 1 : n;
    @(posedge clk); #1;
    start = 1'b1;
    n_terms = 8'(n);
    @(posedge clk); #1;
    start = 1'b0;
    n_terms = 8'($urandom_range(0, 255));
    adds0 = add_cnt;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    check({tag, "_res_clr"}, {24'd0, result}, 32'd0);
    check({tag, "_ovf_clr"}, {31'd0, overflow}, 32'd0);
    wait_done(tag, lat);
    check({tag, "_lat"}, lat, 3 * nn);
    check({tag, "_result"}, {24'd0, result}, {24'd0, exp_res});
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    check({tag, "_adds"}, add_cnt - adds0, nn - 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_res_hold"}, {24'd0, result}, {24'd0, exp_res});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, 32'd0);
    check({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    check({tag, "_enw"}, {31'd0, enW}, 32'd0);
    check({tag, "_rs"}, {27'd0, RS}, 32'd0);
    check({tag, "_rt"}, {27'd0, RT}, 32'd0);
    check({tag, "_rd"}, {30'd0, RD}, 32'd0);
    check({tag, "_din"}, {24'd0, Data_in}, 32'd0);
  endtask

  initial begin
    int pulses, lat;
    reset = 1'b0;
    start = 1'b0;
    n_terms = 8'd0;
    #1;
    check_all_zero("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run(10, 8'd55, 1'b0, "n10");
    run(0, 8'd0, 1'b0, "n0");
    run(1, 8'd1, 1'b0, "n1");
    run(13, 8'd233, 1'b0, "n13");
    run(14, 8'd121, 1'b1, "n14");

    // start held high across a whole n=5 run: one done, re-accept only from IDLE
    @(posedge clk); #1;
    start = 1'b1;
    n_terms = 8'd5;
    @(posedge clk); #1;
    pulses = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (done) begin
        pulses++;
        check("hold_done_cycle", c, 15);
        check("hold_result", {24'd0, result}, 32'd5);
      end
    end
    check("hold_pulses", pulses, 1);
    check("hold_idle_after_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("hold_reaccept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("hold2", lat);
    check("hold2_lat", lat, 15);
    check("hold2_result", {24'd0, result}, 32'd5);

    // reset during MOV0 (cycle 4) of an n=10 run
    @(posedge clk); #1;
    start = 1'b1;
    n_terms = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_all_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst_hold");
    reset = 1'b1;
    run(6, 8'd8, 1'b0, "n6");

    run(255, fib_mod(255), 1'b1, "n255");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
